// File: rtl/rv32i_pkg.sv
// Shared RV32I encoding definitions: instruction formats, opcodes,
// immediate ranges and the encoder FSM state type.
package rv32i_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_t;

  localparam logic [6:0] OP_R    = 7'h33;
  localparam logic [6:0] OP_I    = 7'h13;
  localparam logic [6:0] OP_LOAD = 7'h03;
  localparam logic [6:0] OP_S    = 7'h23;
  localparam logic [6:0] OP_B    = 7'h63;
  localparam logic [6:0] OP_LUI  = 7'h37;
  localparam logic [6:0] OP_JAL  = 7'h6F;

  // Signed byte-offset ranges representable by each immediate format.
  localparam int IMM_I_MIN = -2048;
  localparam int IMM_I_MAX = 2047;
  localparam int IMM_B_MIN = -4096;
  localparam int IMM_B_MAX = 4094;
  localparam int IMM_J_MIN = -(2 ** 20);
  localparam int IMM_J_MAX = (2 ** 20) - 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I field packer with immediate legality check.
// Out-of-range immediates are still packed (truncated) and flagged.
module instr_pack
  import rv32i_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [6:0]  funct7,
  input  logic [31:0] immediate,
  output logic [31:0] instruction,
  output logic        illegal
);

  logic signed [31:0] simm;
  logic               fits_12;
  logic               fits_13;
  logic               fits_21;

  assign simm    = immediate;
  assign fits_12 = (simm >= IMM_I_MIN) && (simm <= IMM_I_MAX);
  assign fits_13 = (simm >= IMM_B_MIN) && (simm <= IMM_B_MAX);
  assign fits_21 = (simm >= IMM_J_MIN) && (simm <= IMM_J_MAX);

  // Pack fields per format; formats 6/7 yield an all-zero word flagged illegal.
  always_comb begin
    instruction = '0;
    illegal     = 1'b0;
    case (fmt)
      FMT_R: instruction = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: begin
        instruction = {immediate[11:0], rs1, funct3, rd, opcode};
        illegal     = !fits_12;
      end
      FMT_S: begin
        instruction = {immediate[11:5], rs2, rs1, funct3, immediate[4:0], opcode};
        illegal     = !fits_12;
      end
      FMT_B: begin
        instruction = {immediate[12], immediate[10:5], rs2, rs1, funct3,
                       immediate[4:1], immediate[11], opcode};
        illegal     = !fits_13 || immediate[0];
      end
      FMT_U: begin
        instruction = {immediate[31:12], rd, opcode};
        illegal     = |immediate[11:0];
      end
      FMT_J: begin
        instruction = {immediate[20], immediate[10:1], immediate[11],
                       immediate[19:12], rd, opcode};
        illegal     = !fits_21 || immediate[0];
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I instruction encoder: accepts field bundles, emits packed
// words with sequential byte addresses through a single output register.
module instr_encoder
  import rv32i_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [2:0]            i_format,
  input  logic [6:0]            i_opcode,
  input  logic [4:0]            i_rd,
  input  logic [2:0]            i_funct3,
  input  logic [4:0]            i_rs1,
  input  logic [4:0]            i_rs2,
  input  logic [6:0]            i_funct7,
  input  logic [WIDTH-1:0]      i_immediate,
  input  logic                  i_last,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [WIDTH-1:0]      o_instruction,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_illegal,
  output logic                  o_done
);

  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(4);

  state_t                  state_reg;
  state_t                  state_next;
  logic [ADDR_WIDTH-1:0]   cnt_reg;
  logic                    start_run;
  logic                    accept;
  logic [WIDTH-1:0]        packed_word;
  logic                    packed_illegal;

  instr_pack u_pack (
    .fmt         (i_format),
    .opcode      (i_opcode),
    .rd          (i_rd),
    .funct3      (i_funct3),
    .rs1         (i_rs1),
    .rs2         (i_rs2),
    .funct7      (i_funct7),
    .immediate   (i_immediate),
    .instruction (packed_word),
    .illegal     (packed_illegal)
  );

  assign accept = i_valid && o_ready;

  // Next-state and handshake decode; ready only in RUN, passing ready through.
  always_comb begin
    state_next = state_reg;
    o_ready    = 1'b0;
    o_done     = 1'b0;
    start_run  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (i_start) begin
          state_next = ST_RUN;
          start_run  = 1'b1;
        end
      end
      ST_RUN: begin
        o_ready = !o_valid || i_ready;
        if (i_valid && o_ready && i_last) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (o_valid && i_ready) state_next = ST_DONE;
      end
      ST_DONE: begin
        o_done = 1'b1;
        if (i_start) begin
          state_next = ST_RUN;
          start_run  = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // Output register and address counter; an accept overwrites any word
  // leaving in the same cycle, so there is no bubble.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid       <= 1'b0;
      o_instruction <= '0;
      o_addr        <= BASE;
      o_illegal     <= 1'b0;
      cnt_reg       <= BASE;
    end else begin
      if (start_run) cnt_reg <= BASE;
      if (accept) begin
        o_valid       <= 1'b1;
        o_instruction <= packed_word;
        o_illegal     <= packed_illegal;
        o_addr        <= cnt_reg;
        cnt_reg       <= cnt_reg + STEP;
      end else if (i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule
